// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared constants for the sequential binary-to-BCD converter:
//                FSM state encodings, BCD digit width and the shift-and-add-3
//                threshold / correction values.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // FSM state encodings
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // One BCD digit is a nibble
    localparam int BCD_DIGIT_W = 4;

    // A digit of 5 or more would exceed 9 after doubling; adding 3 first
    // makes the doubled value carry correctly into the next digit.
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_CORR   = 4'd3;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Combinational double-dabble digit correction. Adds 3 to a
//                BCD digit when it is 5 or more, otherwise passes it through.
//  Ports       : i_digit  in  [3:0]  BCD digit before correction
//                o_digit  out [3:0]  corrected BCD digit
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    logic w_ge_thresh;

    assign w_ge_thresh = (i_digit >= ADD3_THRESH);
    assign o_digit     = w_ge_thresh ? (i_digit + ADD3_CORR) : i_digit;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_seq
//  Description : Sequential binary-to-BCD converter (shift-and-add-3, one
//                input bit per clock) with a start/done handshake. Feeds the
//                seven-segment display driver from the binary time counters.
//  Ports       : clk    in                 system clock, rising edge
//                reset  in                 synchronous active-high reset
//                start  in                 conversion request (IDLE only)
//                bin    in  [BIN_W-1:0]    binary value, captured on accept
//                busy   out                high in SHIFT and DONE
//                done   out                one-cycle result-valid pulse
//                bcd    out [4*DIGITS-1:0] packed BCD, MS digit in top nibble
//                ovf    out                bin exceeds 10^DIGITS - 1
//  Options     : BIN_TO_BCD_CLAMP_EN - when defined, an overflowing result
//                forces bcd to all nines; otherwise the low digits are kept.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          ovf
);

    // One extra guard digit above the result digits catches overflow.
    localparam int SR_W  = BCD_DIGIT_W*(DIGITS+1) + BIN_W;
    localparam int CNT_W = $clog2(BIN_W+1);
    localparam int RES_W = BCD_DIGIT_W*DIGITS;

    logic [1:0]       r_state;
    logic [SR_W-1:0]  r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [RES_W-1:0] r_bcd;
    logic             r_ovf;

    logic [SR_W-1:0]        w_adj;
    logic [SR_W-1:0]        w_next;
    logic [RES_W-1:0]       w_low;
    logic [BCD_DIGIT_W-1:0] w_guard;
    logic                   w_guard_nz;
    logic [RES_W-1:0]       w_bcd_res;

    // Binary part of the register is never corrected, only shifted.
    assign w_adj[BIN_W-1:0] = r_sr[BIN_W-1:0];

    generate
        for (genvar g = 0; g <= DIGITS; g++) begin : g_digit_adj
            bcd_digit_adj u_adj (
                .i_digit (r_sr [BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W]),
                .o_digit (w_adj[BIN_W + BCD_DIGIT_W*g +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Correction happens before the shift, so the final shifted value is
    // already the finished BCD result.
    assign w_next     = w_adj << 1;
    assign w_low      = w_next[BIN_W +: RES_W];
    assign w_guard    = w_next[BIN_W + RES_W +: BCD_DIGIT_W];
    assign w_guard_nz = (w_guard != '0);

`ifdef BIN_TO_BCD_CLAMP_EN
    assign w_bcd_res = w_guard_nz ? {DIGITS{4'h9}} : w_low;
`else
    assign w_bcd_res = w_low;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sr    <= {{(SR_W-BIN_W){1'b0}}, bin};
                        r_cnt   <= CNT_W'(BIN_W);
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last input bit shifts in on this edge.
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_bcd   <= w_bcd_res;
                        r_ovf   <= w_guard_nz;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign ovf  = r_ovf;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd_seq
//  Description : Self-checking bench for bin_to_bcd_seq (BIN_W=7, DIGITS=2).
//                Expected {bcd, ovf} pairs are queued when a conversion is
//                launched and compared whenever the DUT pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 7;
    localparam int DIGITS = 2;

    logic                clk;
    logic                reset;
    logic                start;
    logic [BIN_W-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;
    logic                ovf;

    int n_cmp;
    int n_err;

    logic [8:0] exp_q[$];

    bin_to_bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits computed arithmetically.
    task automatic push_exp(input int v);
        logic [7:0] e_bcd;
        logic       e_ovf;
        e_bcd = {4'((v / 10) % 10), 4'(v % 10)};
        e_ovf = (v > 99);
`ifdef BIN_TO_BCD_CLAMP_EN
        if (e_ovf) e_bcd = 8'h99;
`endif
        exp_q.push_back({e_bcd, e_ovf});
    endtask

    // Result monitor
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("bcd", 32'(bcd), 32'(e[8:1]));
                check_eq("ovf", 32'(ovf), 32'(e[0]));
            end
        end
    end

    // Single conversion with latency and busy-length checks.
    task automatic run_conv(input int v);
        int done_at;
        int busy_n;
        done_at = 0;
        busy_n  = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 7'(v);
        push_exp(v);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                bin   = 7'($urandom);
            end
            if (busy) busy_n++;
            if (done && done_at == 0) done_at = i;
        end
        check_eq("latency", 32'(done_at), 32'd8);
        check_eq("busy_len", 32'(busy_n), 32'd8);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n_done;
        int d[3];
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_bcd",  32'(bcd),  32'd0);
        check_eq("rst_ovf",  32'(ovf),  32'd0);

        run_conv(0);
        run_conv(59);
        run_conv(99);
        run_conv(127);

        // Start while busy is ignored.
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 7'd23;
        push_exp(23);
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b0; bin = 7'd45; end
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (done) n_done++;
        end
        check_eq("ignore_done_cnt", 32'(n_done), 32'd1);

        // Reset mid-conversion discards the result.
        n_done = 0;
        @(negedge clk);
        start = 1'b1;
        bin   = 7'd59;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (i == 4) reset = 1'b1;
            if (i == 5) begin
                reset = 1'b0;
                check_eq("midrst_busy", 32'(busy), 32'd0);
                check_eq("midrst_bcd",  32'(bcd),  32'd0);
                check_eq("midrst_ovf",  32'(ovf),  32'd0);
            end
            if (done) n_done++;
        end
        check_eq("midrst_no_done", 32'(n_done), 32'd0);
        run_conv(12);

        // Start held high: one conversion every 9 cycles.
        n_done = 0;
        d = '{0, 0, 0};
        @(negedge clk);
        start = 1'b1;
        bin   = 7'd7;
        push_exp(7);
        push_exp(7);
        push_exp(7);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 20) start = 1'b0;
            if (done) begin
                if (n_done < 3) d[n_done] = i;
                n_done++;
            end
        end
        check_eq("held_cnt",  32'(n_done), 32'd3);
        check_eq("held_gap1", 32'(d[1] - d[0]), 32'd9);
        check_eq("held_gap2", 32'(d[2] - d[1]), 32'd9);
        check_eq("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
